// File: rtl/mod461_pkg.sv
// Shared GF(461) constants and types for the mod-461 arithmetic blocks.
// The CHK state only exists when MOD_INV_461_SELFCHECK_EN is defined.
package mod461_pkg;

   localparam int P = 461;
   localparam int W = $clog2(P);
   localparam logic [W-1:0] EXP = W'(P - 2);

   typedef logic [W-1:0]          residue_t;
   typedef logic [$clog2(W)-1:0]  idx_t;

   typedef enum logic [2:0] {
      IDLE,
      SQR,
      MUL,
`ifdef MOD_INV_461_SELFCHECK_EN
      CHK,
`endif
      DONE
   } state_t;

endpackage

// File: rtl/mod461_mulred.sv
// Combinational (a*b) mod 461: 18-bit product folded with 2^9 = 51 (mod 461),
// then one conditional subtract; zero latency, no flow control.
module mod461_mulred
   import mod461_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] r
);

   localparam int FOLD = (1 << W) % P;

   logic [2*W-1:0] prod;
   logic [14:0]    s1;
   logic [11:0]    s2;
   logic [9:0]     s3;
   logic [9:0]     s4;

   // Each fold stage is sized so that even 511*511 cannot overflow it;
   // after the last fold the value is below 2P, so one subtract suffices.
   always_comb begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      s1   = 15'(prod[17:9]) * 15'(FOLD) + 15'(prod[8:0]);
      s2   = 12'(s1[14:9]) * 12'(FOLD) + 12'(s1[8:0]);
      s3   = 10'(s2[11:9]) * 10'(FOLD) + 10'(s2[8:0]);
      s4   = (s3[9] ? 10'(FOLD) : 10'd0) + 10'(s3[8:0]);
      r    = (s4 >= 10'(P)) ? W'(s4 - 10'(P)) : W'(s4);
   end

endmodule

// File: rtl/mod_inv_461.sv
// Fermat inverse a^459 mod 461, one modular multiply per clock; result valid 15 cycles
// after accept (16 with MOD_INV_461_SELFCHECK_EN). Result held until out_ready; in_ready only in IDLE.
module mod_inv_461
   import mod461_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_inv,
   output logic         out_err
`ifdef MOD_INV_461_SELFCHECK_EN
   ,
   output logic         check_fail
`endif
);

`ifdef MOD_INV_461_SELFCHECK_EN
   localparam state_t ST_LAST = CHK;
`else
   localparam state_t ST_LAST = DONE;
`endif

   state_t   state, state_nxt;
   residue_t acc, a_reg, mul_b, prod;
   idx_t     idx;
   logic     err, in_err, idx_dec;

   assign in_err = (in_a == '0) || (in_a >= W'(P));
   assign mul_b  = (state == SQR) ? acc : a_reg;

   mod461_mulred u_mulred (
      .a (acc),
      .b (mul_b),
      .r (prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      idx_dec   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SQR;
         end
         SQR: begin
            if (EXP[idx])         state_nxt = MUL;
            else if (idx == '0)   state_nxt = ST_LAST;
            else                  idx_dec   = 1'b1;
         end
         MUL: begin
            if (idx == '0) state_nxt = ST_LAST;
            else begin
               idx_dec   = 1'b1;
               state_nxt = SQR;
            end
         end
`ifdef MOD_INV_461_SELFCHECK_EN
         CHK:     state_nxt = DONE;
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Error operands are masked to zero so the schedule stays constant-time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= W'(1);
         a_reg   <= '0;
         idx     <= idx_t'(W - 1);
         err     <= 1'b0;
         out_inv <= '0;
         out_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= in_err ? '0 : in_a;
                  acc   <= W'(1);
                  idx   <= idx_t'(W - 1);
                  err   <= in_err;
               end
            end
            SQR, MUL: begin
               acc <= prod;
               if (idx_dec) idx <= idx - idx_t'(1);
               if (state_nxt == DONE) begin
                  out_inv <= err ? '0 : prod;
                  out_err <= err;
               end
            end
`ifdef MOD_INV_461_SELFCHECK_EN
            CHK: begin
               out_inv <= err ? '0 : acc;
               out_err <= err;
            end
`endif
            default: ;
         endcase
      end
   end

`ifdef MOD_INV_461_SELFCHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  check_fail <= 1'b0;
      else if (state == CHK)                    check_fail <= !err && (prod != W'(1));
      else if ((state == DONE) && out_ready)    check_fail <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_mod_inv_461.sv
// Directed bench for mod_inv_461: reset, known inverses, error operands,
// backpressure hold, mid-operation reset and a full 1..460 sweep.
module tb_mod_inv_461;

`ifdef MOD_INV_461_SELFCHECK_EN
   localparam int LAT = 16;
`else
   localparam int LAT = 15;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [8:0] in_a = 9'd0;
   logic       in_ready, out_valid, out_err;
   logic [8:0] out_inv;
`ifdef MOD_INV_461_SELFCHECK_EN
   logic       check_fail;
`endif

   int total = 0;
   int bad   = 0;

   mod_inv_461 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inv   (out_inv),
      .out_err   (out_err)
`ifdef MOD_INV_461_SELFCHECK_EN
      ,
      .check_fail(check_fail)
`endif
   );

   always #5 clk = ~clk;

   // Offers a, returns cycles from accepting edge to out_valid (capped at 40).
   task automatic run_op(input logic [8:0] a, output int lat,
                         output logic [8:0] inv, output logic err);
      int n;
      @(negedge clk);
      in_a = a;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = ~a;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      inv = out_inv;
      err = out_err;
   endtask

   task automatic retire();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_inv !== 9'd0) begin bad++; $display("FAIL reset_out_inv got=%0d want=0", out_inv); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%0b want=0", out_err); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
   endtask

   task automatic test_values();
      logic [8:0] av [5] = '{9'd1, 9'd2, 9'd3, 9'd10, 9'd460};
      logic [8:0] ev [5] = '{9'd1, 9'd231, 9'd154, 9'd415, 9'd460};
      int lat;
      logic [8:0] inv;
      logic err;
      for (int i = 0; i < 5; i++) begin
         run_op(av[i], lat, inv, err);
         total++; if (inv !== ev[i]) begin bad++; $display("FAIL value_inv a=%0d got=%0d want=%0d", av[i], inv, ev[i]); end
         total++; if (err !== 1'b0) begin bad++; $display("FAIL value_err a=%0d got=%0b want=0", av[i], err); end
         total++; if (lat != LAT) begin bad++; $display("FAIL value_latency a=%0d got=%0d want=%0d", av[i], lat, LAT); end
         retire();
      end
   endtask

   task automatic test_err();
      logic [8:0] av [2] = '{9'd0, 9'd461};
      int lat;
      logic [8:0] inv;
      logic err;
      for (int i = 0; i < 2; i++) begin
         run_op(av[i], lat, inv, err);
         total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag a=%0d got=%0b want=1", av[i], err); end
         total++; if (inv !== 9'd0) begin bad++; $display("FAIL err_inv a=%0d got=%0d want=0", av[i], inv); end
         total++; if (lat != LAT) begin bad++; $display("FAIL err_latency a=%0d got=%0d want=%0d", av[i], lat, LAT); end
`ifdef MOD_INV_461_SELFCHECK_EN
         total++; if (check_fail !== 1'b0) begin bad++; $display("FAIL err_check_fail a=%0d got=%0b want=0", av[i], check_fail); end
`endif
         retire();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [8:0] inv;
      logic err;
      run_op(9'd3, lat, inv, err);
      total++; if (inv !== 9'd154) begin bad++; $display("FAIL bp_first got=%0d want=154", inv); end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || out_inv !== 9'd154 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%0b inv=%0d in_ready=%0b want 1/154/0", c, out_valid, out_inv, in_ready);
         end
      end
      retire();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release in_ready=%0b valid=%0b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_mid_reset();
      int lat;
      logic [8:0] inv;
      logic err;
      @(negedge clk);
      in_a = 9'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_abort valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
      run_op(9'd10, lat, inv, err);
      total++; if (inv !== 9'd415 || lat != LAT) begin bad++; $display("FAIL midrst_fresh inv=%0d lat=%0d want 415/%0d", inv, lat, LAT); end
      retire();
   endtask

   task automatic test_sweep();
      int lat;
      logic [8:0] inv;
      logic err;
      int prodmod;
      for (int a = 1; a < 461; a++) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         run_op(9'(a), lat, inv, err);
         prodmod = (int'(inv) * a) % 461;
         total++;
         if (prodmod != 1 || err !== 1'b0 || lat != LAT) begin
            bad++;
            $display("FAIL sweep a=%0d inv=%0d prod=%0d err=%0b lat=%0d want prod=1 err=0 lat=%0d", a, inv, prodmod, err, lat, LAT);
         end
`ifdef MOD_INV_461_SELFCHECK_EN
         total++; if (check_fail !== 1'b0) begin bad++; $display("FAIL sweep_check_fail a=%0d got=%0b want=0", a, check_fail); end
`endif
         repeat ($urandom_range(0, 3)) @(posedge clk);
         retire();
      end
   endtask

   initial begin
      test_reset();
      test_values();
      test_err();
      test_backpressure();
      test_mid_reset();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_inv_461.md
Name: mod_inv_461

Overview:
- Sequential modular inverter over GF(461): accepts a 9-bit residue a and returns a^-1 mod 461.
- Inverse direction of the combinational mod-461 multiplier LUT blocks: downstream modular-division paths use it to undo a multiplication.
- Computes by Fermat exponentiation, a^(P-2) mod P, with left-to-right square-and-multiply and one modular multiply per clock.
- Valid/ready handshake on both input and output.

Parameters:
- P, 461, prime modulus; must be prime.
- W, 9, operand/result width; must equal clog2(P).
- EXP, P-2 (459 = 9'b111001011), exponent; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_a  input  W  operand a, expected range 1..P-1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_inv  output  W  a^-1 mod P.
- out_err  output  1  operand was 0 or >= P.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; acc=1; a_reg=0; bit index=W-1; out_valid=0; out_inv=0; out_err=0. in_ready=1 once rst deasserts.
- Reset asserted mid-operation aborts the computation immediately; no partial result is ever presented.
- FSM states: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a_reg=in_a, acc=1, idx=8, err=(in_a==0 || in_a>=P). Go to SQR.
- SQR:
  - acc <= acc*acc mod P.
  - If EXP[idx]=1, go to MUL.
  - Else if idx==0, go to DONE.
  - Else idx--, stay in SQR.
- MUL:
  - acc <= acc*a_reg mod P.
  - If idx==0, go to DONE; else idx-- and go to SQR.
- Timing:
  - Fixed schedule: 9 squares + 6 multiplies = 15 compute cycles.
  - out_valid rises on the 15th clock edge after the accepting edge, independent of operand value.
- DONE:
  - out_valid=1, out_inv=acc. If err, out_inv is forced to 0.
  - Outputs hold stable while out_valid & !out_ready.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so a new operand cannot be accepted in the same cycle the result is taken. One-cycle bubble; minimum issue interval 17 cycles.
- Arithmetic:
  - 2W-bit product, reduced to [0,P-1] in the same cycle by a combinational reducer.
  - No intermediate value ever reaches >= P.
- Error operands still run the full 15-cycle schedule (constant-time). a_reg is masked to 0 for err, so acc is 0.
- in_a is sampled only on the accepting edge; later changes are ignored.

Optional Feature:
- Macro MOD_INV_461_SELFCHECK_EN.
- With the macro defined:
  - One extra state CHK after the final operation computes acc*a_reg mod P.
  - Adds port check_fail (output, 1): set in DONE when err=0 and the product != 1; cleared on leaving DONE.
  - Latency becomes 16 cycles.
- Without the macro: no CHK state, no check_fail port, latency 15.

Decomposition:
- Shared package mod461_pkg holds:
  - P, W, EXP constants.
  - State enum typedef.
  - Residue typedef (logic [W-1:0]).
- One sub-module, mod461_mulred: combinational W x W multiply followed by mod-P reduction (2W-bit to W-bit).
  - Shared between the SQR and MUL paths through an operand mux.
  - Reusable by other mod-461 blocks.

Test Plan:
- in_a=1 → after 15 cycles out_valid=1, out_inv=1, out_err=0.
- in_a=2, 3, 10, 460 in sequence → out_inv=231, 154, 415, 460 respectively; each 15 cycles after accept.
- in_a=0, then in_a=461 → out_err=1, out_inv=0, latency still 15.
- Hold out_ready=0 for 20 cycles after out_valid → out_inv stays stable, in_ready=0 throughout; assert out_ready → IDLE on the next edge, in_ready=1.
- Assert rst 7 cycles into a computation → out_valid=0 and in_ready=1 next cycle; a fresh in_a=10 returns 415.
- Exhaustive sweep a=1..460 with random out_ready backpressure → out_inv*a mod 461 == 1 for all; with MOD_INV_461_SELFCHECK_EN, check_fail never asserts and latency is 16.
